// File: rtl/ps2_pkg.sv
// Shared types and constants for the host-side PS/2 transmitter.
package ps2_pkg;

   // Transfer sequencing states of the host transmitter.
   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SEND,
      ACK,
      RELEASE,
      DONE
   } ps2_state_t;

   // Cycles the synchronised pin must hold a new level before it is accepted.
   localparam int FILT_LEN = 4;

   // Data bits + parity + stop shifted out after the start bit.
   localparam int FRAME_BITS = 10;

   // Clock-line inhibit length in clk cycles.
   function automatic int calc_inhibit_cyc(input int clkfreq_khz, input int inhibit_us);
      return (clkfreq_khz * inhibit_us) / 1000;
   endfunction

   // Transfer timeout in clk cycles.
   function automatic int calc_timeout_cyc(input int clkfreq_khz, input int timeout_ms);
      return clkfreq_khz * timeout_ms;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter for one PS/2 pin.
// The output level follows the pin only after it has been steady for
// FILT_LEN consecutive cycles, so short glitches never reach the FSM.
module ps2_line_filter
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic pin_in,
   output logic level
);

   localparam int CNT_W = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;

   logic             sync1_reg;
   logic             sync2_reg;
   logic             level_reg;
   logic [CNT_W-1:0] cnt_reg;

   // Bring the asynchronous pin into the clk domain (idle level is high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
      end else begin
         sync1_reg <= pin_in;
         sync2_reg <= sync1_reg;
      end
   end

   // Count consecutive cycles of disagreement; adopt the new level on the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_reg <= 1'b1;
         cnt_reg   <= '0;
      end else if (sync2_reg == level_reg) begin
         cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(FILT_LEN - 1)) begin
         level_reg <= sync2_reg;
         cnt_reg   <= '0;
      end else begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign level = level_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues the
// request-to-send, shifts one byte out on device clock falls and samples
// the device acknowledge, guarded by an overall timeout.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLKFREQ_KHZ = 7000,
   parameter int INHIBIT_US  = 120,
   parameter int TIMEOUT_MS  = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] din,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       error,
   input  logic       ps2clk_in,
   input  logic       ps2data_in,
   output logic       ps2clk_oe,
   output logic       ps2data_oe
);

   localparam int INHIBIT_CYC = calc_inhibit_cyc(CLKFREQ_KHZ, INHIBIT_US);
   localparam int TIMEOUT_CYC = calc_timeout_cyc(CLKFREQ_KHZ, TIMEOUT_MS);
   localparam int INH_W       = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
   localparam int TMO_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   ps2_state_t state_reg, state_next;
   logic [FRAME_BITS-1:0] shreg_reg, shreg_next;
   logic [3:0]            bitcnt_reg, bitcnt_next;
   logic [INH_W-1:0]      inh_cnt_reg, inh_cnt_next;
   logic [TMO_W-1:0]      tmo_cnt_reg, tmo_cnt_next;
   logic                  ack_ok_reg, ack_ok_next;
   logic                  error_reg, error_next;
   logic                  data_oe_reg, data_oe_next;
   logic                  clk_prev_reg;

   logic clk_filt;
   logic data_filt;
   logic clk_fall;
   logic tmo_expired;

   ps2_line_filter u_clk_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_in (ps2clk_in),
      .level  (clk_filt)
   );

   ps2_line_filter u_data_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_in (ps2data_in),
      .level  (data_filt)
   );

   // Falling edge of the filtered device clock, high for exactly one cycle.
   assign clk_fall    = clk_prev_reg & ~clk_filt;
   assign tmo_expired = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

   // State and datapath registers; reset releases both lines immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         shreg_reg    <= '0;
         bitcnt_reg   <= '0;
         inh_cnt_reg  <= '0;
         tmo_cnt_reg  <= '0;
         ack_ok_reg   <= 1'b0;
         error_reg    <= 1'b0;
         data_oe_reg  <= 1'b0;
         clk_prev_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         shreg_reg    <= shreg_next;
         bitcnt_reg   <= bitcnt_next;
         inh_cnt_reg  <= inh_cnt_next;
         tmo_cnt_reg  <= tmo_cnt_next;
         ack_ok_reg   <= ack_ok_next;
         error_reg    <= error_next;
         data_oe_reg  <= data_oe_next;
         clk_prev_reg <= clk_filt;
      end
   end

   // Next-state and datapath decisions for one host-to-device transfer.
   always_comb begin
      state_next   = state_reg;
      shreg_next   = shreg_reg;
      bitcnt_next  = bitcnt_reg;
      inh_cnt_next = inh_cnt_reg;
      tmo_cnt_next = tmo_cnt_reg;
      ack_ok_next  = ack_ok_reg;
      error_next   = error_reg;
      data_oe_next = data_oe_reg;

      case (state_reg)
         IDLE: begin
            data_oe_next = 1'b0;
            if (start) begin
               // Frame is stop, odd parity, then the byte, shifted out LSB first.
               shreg_next   = {1'b1, ~^din, din};
               ack_ok_next  = 1'b0;
               error_next   = 1'b0;
               bitcnt_next  = '0;
               inh_cnt_next = '0;
               state_next   = INHIBIT;
            end
         end
         INHIBIT: begin
            tmo_cnt_next = '0;
            if (inh_cnt_reg == INH_W'(INHIBIT_CYC - 1)) begin
               state_next = RTS;
            end else begin
               inh_cnt_next = inh_cnt_reg + INH_W'(1);
            end
         end
         RTS: begin
            // Data pulled low here is the start bit; it stays low into SEND.
            data_oe_next = 1'b1;
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            state_next   = SEND;
         end
         SEND: begin
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            if (tmo_expired) begin
               error_next   = 1'b1;
               ack_ok_next  = 1'b0;
               data_oe_next = 1'b0;
               state_next   = DONE;
            end else if (clk_fall) begin
               data_oe_next = ~shreg_reg[0];
               shreg_next   = {1'b0, shreg_reg[FRAME_BITS-1:1]};
               bitcnt_next  = bitcnt_reg + 4'd1;
               if (bitcnt_reg == 4'(FRAME_BITS - 1)) begin
                  state_next = ACK;
               end
            end
         end
         ACK: begin
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            if (tmo_expired) begin
               error_next   = 1'b1;
               ack_ok_next  = 1'b0;
               data_oe_next = 1'b0;
               state_next   = DONE;
            end else if (clk_fall) begin
               ack_ok_next  = ~data_filt;
               data_oe_next = 1'b0;
               state_next   = RELEASE;
            end
         end
         RELEASE: begin
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            if (tmo_expired) begin
               // The sampled acknowledge is kept; only the error flag is raised.
               error_next = 1'b1;
               state_next = DONE;
            end else if (clk_filt && data_filt) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy       = (state_reg != IDLE);
   assign done       = (state_reg == DONE);
   assign ack_ok     = ack_ok_reg;
   assign error      = error_reg;
   assign ps2clk_oe  = (state_reg == INHIBIT) || (state_reg == RTS);
   assign ps2data_oe = (state_reg == RTS) ||
                       (((state_reg == SEND) || (state_reg == ACK)) && data_oe_reg);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

   localparam int CLK_KHZ     = 7000;
   localparam int INH_US      = 120;
   localparam int TMO_MS      = 2;
   localparam int INHIBIT_CYC = CLK_KHZ * INH_US / 1000;
   localparam int TIMEOUT_CYC = CLK_KHZ * TMO_MS;

   typedef enum int {M_NORMAL, M_NODEV, M_ABORT} dmode_t;
   typedef struct {
      dmode_t mode;
      int     period;
      bit     ack;
      bit     glitch;
   } dcfg_t;
   typedef struct {
      logic [7:0] din;
      bit         ack;
      bit         err;
      bit         tmo;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] din = 8'h00;
   logic       busy, done, ack_ok, error, ps2clk_oe, ps2data_oe;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2clk_in, ps2data_in;

   // Open-drain wiring: either side can pull a line low.
   assign ps2clk_in  = dev_clk & ~ps2clk_oe;
   assign ps2data_in = dev_data & ~ps2data_oe;

   dcfg_t      dev_q[$];
   exp_t       exp_q[$];
   logic [9:0] cap_q[$];

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int unsigned rts_cyc = 0;
   int          inh_run = 0;
   int          last_inh = 0;
   bit          abort_flag = 1'b0;

   ps2_host_tx #(
      .CLKFREQ_KHZ (CLK_KHZ),
      .INHIBIT_US  (INH_US),
      .TIMEOUT_MS  (TMO_MS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .din        (din),
      .busy       (busy),
      .done       (done),
      .ack_ok     (ack_ok),
      .error      (error),
      .ps2clk_in  (ps2clk_in),
      .ps2data_in (ps2data_in),
      .ps2clk_oe  (ps2clk_oe),
      .ps2data_oe (ps2data_oe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference frame: data LSB first, odd parity (set when the byte has an even count of ones), stop=1.
   function automatic logic [9:0] ref_frame(input logic [7:0] b);
      bit par;
      par = (($countones(b) % 2) == 0);
      return {1'b1, par, b};
   endfunction

   // Measure inhibit length and note the request-to-send cycle (both lines pulled).
   always @(negedge clk) begin
      if (!rst_n) begin
         inh_run <= 0;
      end else if (ps2clk_oe && ps2data_oe) begin
         last_inh <= inh_run;
         rts_cyc  <= cyc;
         inh_run  <= 0;
      end else if (ps2clk_oe) begin
         inh_run <= inh_run + 1;
      end
   end

   // Device model: answers a host request by clocking in the frame.
   task automatic run_device(input dcfg_t c);
      int half, q, t;
      logic [9:0] bits;
      half = c.period / 2;
      q    = c.period / 4;
      bits = '0;
      t = 0;
      while (ps2clk_in !== 1'b0 && t < 5000) begin @(negedge clk); t++; end
      if (t >= 5000) begin check("dev_wait_inhibit", ps2clk_in, 0); return; end
      t = 0;
      while (!(ps2clk_in === 1'b1 && ps2data_in === 1'b0) && t < 5000) begin @(negedge clk); t++; end
      if (t >= 5000) begin check("dev_wait_rts", ps2data_in, 0); return; end
      wait_cyc(half);
      for (int i = 0; i < 10; i++) begin
         dev_clk = 1'b0;
         wait_cyc(half);
         dev_clk = 1'b1;
         bits[i] = ps2data_in;
         if (c.mode == M_ABORT && i == 3) begin
            abort_flag = 1'b1;
            return;
         end
         if (c.glitch && i == 3) begin
            wait_cyc(q);
            dev_clk = 1'b0;
            wait_cyc(2);
            dev_clk = 1'b1;
            wait_cyc(half - q - 2);
         end else begin
            wait_cyc(half);
         end
      end
      cap_q.push_back(bits);
      if (c.ack) dev_data = 1'b0;
      wait_cyc(q);
      dev_clk = 1'b0;
      wait_cyc(half);
      dev_clk = 1'b1;
      wait_cyc(q);
      dev_data = 1'b1;
   endtask

   initial begin : device_proc
      dcfg_t c;
      forever begin
         @(negedge clk);
         if (dev_q.size() > 0) begin
            c = dev_q.pop_front();
            if (c.mode != M_NODEV) run_device(c);
         end
      end
   end

   // Monitor: every done pulse is matched against the oldest expectation.
   initial begin : monitor_proc
      exp_t e;
      logic [9:0] cap;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", {31'd0, done}, 0);
            end else begin
               e = exp_q.pop_front();
               $display("xfer din=%02h ack_ok=%0b error=%0b cycle=%0d", e.din, ack_ok, error, cyc);
               check("ack_ok", {31'd0, ack_ok}, {31'd0, e.ack});
               check("error", {31'd0, error}, {31'd0, e.err});
               check("oe_at_done", {30'd0, ps2clk_oe, ps2data_oe}, 0);
               check("inhibit_len", last_inh, INHIBIT_CYC);
               if (e.tmo) begin
                  check("timeout_cycles", cyc - rts_cyc, TIMEOUT_CYC);
               end else if (cap_q.size() > 0) begin
                  cap = cap_q.pop_front();
                  check("frame", {22'd0, cap}, {22'd0, ref_frame(e.din)});
               end else begin
                  check("frame_missing", cap_q.size(), 1);
               end
               @(negedge clk);
               check("busy_after_done", {31'd0, busy}, 0);
               check("oe_after_done", {30'd0, ps2clk_oe, ps2data_oe}, 0);
               check("ack_ok_held", {31'd0, ack_ok}, {31'd0, e.ack});
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, input dmode_t mode, input int period,
                       input bit ack, input bit glitch);
      dcfg_t c;
      exp_t  e;
      c.mode = mode; c.period = period; c.ack = ack; c.glitch = glitch;
      dev_q.push_back(c);
      if (mode != M_ABORT) begin
         e.din = b;
         e.err = (mode == M_NODEV);
         e.tmo = e.err;
         e.ack = e.err ? 1'b0 : ack;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b1;
      din   = b;
      @(negedge clk);
      start = 1'b0;
      din   = 8'($urandom);
      check("clk_oe_after_start", {31'd0, ps2clk_oe}, 1);
      check("busy_after_start", {31'd0, busy}, 1);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy !== 1'b0 && t < 30000) begin @(negedge clk); t++; end
      if (t >= 30000) check("idle_timeout", {31'd0, busy}, 0);
      wait_cyc(20);
   endtask

   initial begin : stim_proc
      logic [7:0] pbytes [3];
      logic [7:0] b;
      int t;
      pbytes[0] = 8'h00; pbytes[1] = 8'hFF; pbytes[2] = 8'h01;

      wait_cyc(3);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_ack_ok", {31'd0, ack_ok}, 0);
      check("rst_error", {31'd0, error}, 0);
      check("rst_oe", {30'd0, ps2clk_oe, ps2data_oe}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(10);

      // LED command at a 12.5 kHz device clock.
      send(8'hED, M_NORMAL, 560, 1'b1, 1'b0);
      wait_idle();

      // Parity corner bytes.
      for (int i = 0; i < 3; i++) begin
         send(pbytes[i], M_NORMAL, 200, 1'b1, 1'b0);
         wait_idle();
      end

      // No device attached.
      send(8'hF4, M_NODEV, 0, 1'b0, 1'b0);
      wait_idle();

      // Device refuses acknowledge.
      send(8'h5A, M_NORMAL, 200, 1'b0, 1'b0);
      wait_idle();

      // Short low glitch on the clock line during SEND.
      send(8'hC3, M_NORMAL, 200, 1'b1, 1'b1);
      wait_idle();

      // Start requests while busy are ignored.
      send(8'h96, M_NORMAL, 200, 1'b1, 1'b0);
      wait_cyc(100);
      start = 1'b1; din = 8'h69;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(1900);
      start = 1'b1; din = 8'h00;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Reset in the middle of SEND.
      abort_flag = 1'b0;
      send(8'h00, M_ABORT, 200, 1'b1, 1'b0);
      t = 0;
      while (!abort_flag && t < 5000) begin @(negedge clk); t++; end
      if (t >= 5000) check("abort_reach_send", {31'd0, abort_flag}, 1);
      wait_cyc(10);
      check("data_oe_before_reset", {31'd0, ps2data_oe}, 1);
      rst_n = 1'b0;
      #1;
      check("oe_in_reset", {30'd0, ps2clk_oe, ps2data_oe}, 0);
      check("busy_in_reset", {31'd0, busy}, 0);
      wait_cyc(5);
      rst_n = 1'b1;
      wait_cyc(3000);

      // Randomised transfers.
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         send(b, M_NORMAL, 2 * $urandom_range(60, 150),
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
         wait_idle();
      end

      wait_cyc(10);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte from the FPGA to a PS/2 keyboard or mouse, for example keyboard LED updates (0xED) or mouse reset/enable (0xFF/0xF4). It is the send half of the host-side PS/2 port and complements the existing PS/2 receivers. It sits between the control logic and the open-drain `clkps2`/`dataps2` or `mouseclk`/`mousedata` pins. The top level builds each pin as "oe ? 0 : Z" and feeds the pin back into the inputs.

## Interface
- `CLKFREQ_KHZ`, 7000, frequency of `clk` in kHz.
- `INHIBIT_US`, 120, time the clock line is held low before the request-to-send, in µs.
- `TIMEOUT_MS`, 15, limit from start of transfer to the acknowledge, in ms.

Ports:
- `clk` in 1: system clock (clk7 domain).
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; only accepted while `busy`=0.
- `din` in 8: byte to send; sampled in the same cycle as an accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` up to and including the `done` cycle.
- `done` out 1: one-cycle pulse at the end of a transfer.
- `ack_ok` out 1: device acknowledged; valid while `done`=1 and held until the next `start`.
- `error` out 1: the transfer hit the timeout; valid while `done`=1 and held until the next `start`.
- `ps2clk_in` in 1: raw clock pin, asynchronous.
- `ps2data_in` in 1: raw data pin, asynchronous.
- `ps2clk_oe` out 1: 1 pulls the clock pin low.
- `ps2data_oe` out 1: 1 pulls the data pin low.

## Operation
Both pin inputs pass through a 2-FF synchroniser and then a stability filter. The filtered level changes only after the synchronised value has been stable for 4 consecutive cycles. `fall` is a one-cycle pulse on a 1→0 change of the filtered clock.

On `start`, the block latches `shreg[9:0] = {1'b1 (stop), par, din}` with `par = ~^din` (odd parity). It clears `ack_ok`, `error` and `bitcnt`, then moves to INHIBIT.

State machine:
- IDLE: both `oe`=0.
- INHIBIT: `ps2clk_oe`=1 for `INHIBIT_CYC = CLKFREQ_KHZ*INHIBIT_US/1000` cycles (840 at the defaults), then go to RTS.
- RTS: `ps2clk_oe`=1 and `ps2data_oe`=1 for exactly 1 cycle (this is the start bit). Release the clock and go to SEND.
- SEND: `ps2data_oe` stays 1.
  - On each `fall`: `ps2data_oe <= ~shreg[0]`, shift `shreg` right, `bitcnt++`.
  - After the 10th `fall` (stop bit, data released), go to ACK.
- ACK: on the next `fall`, sample filtered data. Set `ack_ok = ~data` and go to RELEASE.
- RELEASE: wait until filtered clock = 1 and filtered data = 1, then go to DONE.
- DONE: `done`=1 for 1 cycle, then IDLE.

Timeout:
- Timer starts at entry to RTS: `TIMEOUT_CYC = CLKFREQ_KHZ*TIMEOUT_MS` (105000, 17 bits).
- If it expires in SEND or ACK: set `error`=1, `ack_ok`=0, drop both `oe` immediately and go straight to DONE.
- RELEASE is also covered by the timer. On expiry there, `ack_ok` keeps its sampled value, `error`=1, then DONE.

Boundary cases:
- `start` while `busy`: ignored; the latched byte and state are unchanged.
- A `fall` outside SEND or ACK is ignored.
- Reset asserted mid-transfer: both `oe` drop to 0 asynchronously and the FSM goes to IDLE, with no `done` pulse.

## Timing
- Reset values: `busy`=0, `done`=0, `ack_ok`=0, `error`=0, `ps2clk_oe`=0, `ps2data_oe`=0, state IDLE.
- `ps2clk_oe` rises 1 cycle after `start` is accepted.
- Pin input to `fall`: 6 cycles (2 sync + 4 filter).
- Data changes 1 cycle after `fall`. This is well inside the device's low half-period (≥30 µs ≈ 210 cycles).
- `done` comes at least 1 cycle after both lines are seen idle. `busy` drops in the cycle after `done`.
- Devices clock at 10–16.7 kHz. At 7 MHz the filter latency is negligible.

## Structure
- Package `ps2_pkg`:
  - State enum (IDLE, INHIBIT, RTS, SEND, ACK, RELEASE, DONE).
  - Functions computing `INHIBIT_CYC` and `TIMEOUT_CYC` from the parameters.
  - `FILT_LEN`=4.
- Sub-module `ps2_line_filter` (synchroniser plus stability filter, outputs the filtered level), instantiated twice.
- Counter widths come from `$clog2` of the computed constants.

## Test plan
1. Send `din`=0xED; device model clocks at 12.5 kHz (560-cycle period) and acks. Required: model captures bits LSB-first 1,0,1,1,0,1,1,1, parity 1, stop 1; `done` with `ack_ok`=1, `error`=0; both `oe`=0 afterwards.
2. Parity check:
   - 0x00 → parity 1.
   - 0xFF → parity 1.
   - 0x01 → parity 0.
   - Each transfer ends with `ack_ok`=1.
3. No device (clock pin stays high) → `done` exactly 105000 cycles after RTS, with `error`=1 and `ack_ok`=0; `ps2clk_oe`=`ps2data_oe`=0.
4. Device keeps data high at the 11th edge → `done` with `ack_ok`=0 and `error`=0.
5. A 2-cycle low glitch on the clock pin in SEND → no shift; the captured byte is still correct.
6. `start` during a transfer → ignored; the original byte is sent. `rst_n`=0 mid-SEND → both `oe` are 0 in the same cycle and no `done` pulse.
